// File: rtl/partial_sum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator and its floating-point adder:
// state encodings, word geometry, add/sub op codes and count-width helper.
package partial_sum_accumulator_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  // Hidden bit + fraction + three low guard bits used during alignment.
  localparam int EXT_W = MAN_W + 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_CHUNK = 2'd1,
    S_ADD        = 2'd2,
    S_DONE       = 2'd3
  } psa_state_e;

  typedef enum logic {
    AS_IDLE = 1'b0,
    AS_NORM = 1'b1
  } add_state_e;

  function automatic int count_width(input int nc);
    return $clog2(nc + 1);
  endfunction

endpackage

// File: rtl/adder_subtractor_with_start.sv
// Single-precision add/sub with a start/finish handshake. Alignment is done on start,
// then normalisation shifts one bit per cycle, so latency depends on the operands.
module adder_subtractor_with_start
  import partial_sum_accumulator_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         finish,
  output logic [W-1:0] result
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'((1 << EXP_W) - 1);

  logic [W-1:0]     opnd   [2];
  logic             sgn_in [2];
  logic [EXP_W-1:0] exp_in [2];
  logic [EXT_W-1:0] man_in [2];

  assign opnd[0] = a;
  assign opnd[1] = {b[W-1] ^ (op == OP_SUB), b[W-2:0]};

  // Zero-exponent inputs (zero and subnormals) are treated as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign sgn_in[gi] = opnd[gi][W-1];
      assign exp_in[gi] = opnd[gi][W-2 -: EXP_W];
      assign man_in[gi] = (exp_in[gi] == '0) ? '0 : {1'b1, opnd[gi][MAN_W-1:0], 3'b000};
    end
  endgenerate

  logic             swap;
  logic             big_sgn, small_sgn;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [EXT_W-1:0] big_man, small_man, small_aligned;
  logic [EXT_W:0]   aligned_sum;

  always_comb begin
    swap          = {exp_in[1], man_in[1]} > {exp_in[0], man_in[0]};
    big_sgn       = swap ? sgn_in[1] : sgn_in[0];
    small_sgn     = swap ? sgn_in[0] : sgn_in[1];
    big_exp       = swap ? exp_in[1] : exp_in[0];
    small_exp     = swap ? exp_in[0] : exp_in[1];
    big_man       = swap ? man_in[1] : man_in[0];
    small_man     = swap ? man_in[0] : man_in[1];
    exp_diff      = big_exp - small_exp;
    small_aligned = small_man >> exp_diff;
    if (big_sgn == small_sgn) begin
      aligned_sum = {1'b0, big_man} + {1'b0, small_aligned};
    end else begin
      aligned_sum = {1'b0, big_man} - {1'b0, small_aligned};
    end
  end

  add_state_e     state_reg, state_next;
  logic [EXT_W:0] sum_reg, sum_next;
  logic [EXP_W:0] exp_reg, exp_next;
  logic           sgn_reg, sgn_next;
  logic           finish_reg, finish_next;
  logic [W-1:0]   result_reg, result_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= AS_IDLE;
      sum_reg    <= '0;
      exp_reg    <= '0;
      sgn_reg    <= 1'b0;
      finish_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sum_reg    <= sum_next;
      exp_reg    <= exp_next;
      sgn_reg    <= sgn_next;
      finish_reg <= finish_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sum_next    = sum_reg;
    exp_next    = exp_reg;
    sgn_next    = sgn_reg;
    finish_next = 1'b0;
    result_next = result_reg;
    if (flush) begin
      state_next = AS_IDLE;
    end else begin
      case (state_reg)
        AS_IDLE: begin
          if (start) begin
            sum_next   = aligned_sum;
            exp_next   = {1'b0, big_exp};
            sgn_next   = big_sgn;
            state_next = AS_NORM;
          end
        end
        AS_NORM: begin
          if (sum_reg == '0) begin
            result_next = '0;
            finish_next = 1'b1;
            state_next  = AS_IDLE;
          end else if (sum_reg[EXT_W]) begin
            sum_next = sum_reg >> 1;
            exp_next = exp_reg + EXP_ONE;
          end else if (sum_reg[EXT_W-1]) begin
            // Low guard bits are truncated; exponent overflow saturates to infinity.
            if (exp_reg >= EXP_MAX) begin
              result_next = {sgn_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
              result_next = {sgn_reg, exp_reg[EXP_W-1:0], sum_reg[EXT_W-2 -: MAN_W]};
            end
            finish_next = 1'b1;
            state_next  = AS_IDLE;
          end else if (exp_reg <= EXP_ONE) begin
            result_next = '0;
            finish_next = 1'b1;
            state_next  = AS_IDLE;
          end else begin
            sum_next = sum_reg << 1;
            exp_next = exp_reg - EXP_ONE;
          end
        end
        default: state_next = AS_IDLE;
      endcase
    end
  end

  assign finish = finish_reg;
  assign result = result_reg;

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates NC floating-point chunk sums into one dot-product result, using a
// one-entry holding register to absorb chunks that arrive while an add is in flight.
module partial_sum_accumulator
  import partial_sum_accumulator_pkg::*;
#(
  parameter int NC = 4,
  parameter int W  = FP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dot_start,
  input  logic         chunk_valid,
  input  logic [W-1:0] chunk_sum,
  output logic [W-1:0] dot_result,
  output logic         dot_done,
  output logic         busy,
  output logic         overflow_err
);

  localparam int            CW         = count_width(NC);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(NC);

  psa_state_e    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic          hold_valid_reg, hold_valid_next;
  logic [W-1:0]  hold_data_reg, hold_data_next;
  logic          overflow_reg, overflow_next;
  logic [W-1:0]  result_reg, result_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic          add_start_reg, add_start_next;
  logic [W-1:0]  add_a_reg, add_a_next;
  logic [W-1:0]  add_b_reg, add_b_next;

  logic          add_flush;
  logic          add_finish;
  logic [W-1:0]  add_result;
  logic [CW-1:0] count_inc;

  // An abort kills any add still in flight so its finish can never reach the accumulator.
  assign add_flush = dot_start && (state_reg != S_IDLE);
  assign count_inc = count_reg + COUNT_ONE;

  adder_subtractor_with_start #(
    .W (W)
  ) u_adder (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (add_flush),
    .start  (add_start_reg),
    .op     (OP_ADD),
    .a      (add_a_reg),
    .b      (add_b_reg),
    .finish (add_finish),
    .result (add_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      count_reg      <= '0;
      acc_reg        <= '0;
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      overflow_reg   <= 1'b0;
      result_reg     <= '0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      add_start_reg  <= 1'b0;
      add_a_reg      <= '0;
      add_b_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      acc_reg        <= acc_next;
      hold_valid_reg <= hold_valid_next;
      hold_data_reg  <= hold_data_next;
      overflow_reg   <= overflow_next;
      result_reg     <= result_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      add_start_reg  <= add_start_next;
      add_a_reg      <= add_a_next;
      add_b_reg      <= add_b_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    acc_next        = acc_reg;
    hold_valid_next = hold_valid_reg;
    hold_data_next  = hold_data_reg;
    overflow_next   = overflow_reg;
    result_next     = result_reg;
    done_next       = 1'b0;
    busy_next       = busy_reg;
    add_start_next  = 1'b0;
    add_a_next      = add_a_reg;
    add_b_next      = add_b_reg;
    if (dot_start) begin
      state_next      = S_WAIT_CHUNK;
      count_next      = '0;
      acc_next        = '0;
      hold_valid_next = 1'b0;
      overflow_next   = 1'b0;
      busy_next       = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
        end
        S_WAIT_CHUNK: begin
          if (hold_valid_reg) begin
            add_start_next  = 1'b1;
            add_a_next      = acc_reg;
            add_b_next      = hold_data_reg;
            hold_valid_next = chunk_valid;
            hold_data_next  = chunk_sum;
            state_next      = S_ADD;
          end else if (chunk_valid) begin
            if (count_reg == '0) begin
              acc_next   = chunk_sum;
              count_next = COUNT_ONE;
              if (COUNT_ONE == COUNT_LAST) begin
                state_next = S_DONE;
              end
            end else begin
              add_start_next = 1'b1;
              add_a_next     = acc_reg;
              add_b_next     = chunk_sum;
              state_next     = S_ADD;
            end
          end
        end
        S_ADD: begin
          if (add_finish) begin
            acc_next   = add_result;
            count_next = count_inc;
            if (count_inc == COUNT_LAST) begin
              state_next = S_DONE;
            end else if (hold_valid_reg) begin
              // Chain straight into the next add; a same-cycle chunk refills the slot.
              add_start_next  = 1'b1;
              add_a_next      = add_result;
              add_b_next      = hold_data_reg;
              hold_valid_next = chunk_valid;
              hold_data_next  = chunk_sum;
            end else begin
              hold_valid_next = chunk_valid;
              hold_data_next  = chunk_sum;
              state_next      = S_WAIT_CHUNK;
            end
          end else if (chunk_valid) begin
            if (hold_valid_reg) begin
              overflow_next = 1'b1;
            end else begin
              hold_valid_next = 1'b1;
              hold_data_next  = chunk_sum;
            end
          end
        end
        S_DONE: begin
          result_next     = acc_reg;
          done_next       = 1'b1;
          busy_next       = 1'b0;
          hold_valid_next = 1'b0;
          state_next      = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign dot_result   = result_reg;
  assign dot_done     = done_reg;
  assign busy         = busy_reg;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Self-checking bench: table-driven NC=4 runs plus hand-written overflow, abort, reset
// and NC=1 sequences; expected results queue at dot_start and are checked at dot_done.
module tb_partial_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        dot_start4, chunk_valid4, dot_done4, busy4, ovf4;
  logic [31:0] chunk_sum4, dot_result4;
  logic        dot_start1, chunk_valid1, dot_done1, busy1, ovf1;
  logic [31:0] chunk_sum1, dot_result1;

  partial_sum_accumulator #(.NC(4), .W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .dot_start(dot_start4), .chunk_valid(chunk_valid4),
    .chunk_sum(chunk_sum4), .dot_result(dot_result4), .dot_done(dot_done4),
    .busy(busy4), .overflow_err(ovf4)
  );

  partial_sum_accumulator #(.NC(1), .W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .dot_start(dot_start1), .chunk_valid(chunk_valid1),
    .chunk_sum(chunk_sum1), .dot_result(dot_result1), .dot_done(dot_done1),
    .busy(busy1), .overflow_err(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0][31:0] c;
    int               gap;
    logic [31:0]      exp;
  } vec_t;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   chunk1_cyc = 0;
  logic prev_done4 = 1'b0;
  vec_t vecs[5];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dot_done4) begin
      exp_t e;
      check("nc4_done_single_pulse", {31'b0, prev_done4}, 32'd0);
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL nc4_unexpected_done: got result %h with nothing pending", dot_result4);
      end else begin
        e = q4.pop_front();
        $display("txn nc4 result=%h ovf=%b busy=%b (expect %h ovf=%b)",
                 dot_result4, ovf4, busy4, e.result, e.ovf);
        check("nc4_result", dot_result4, e.result);
        check("nc4_overflow", {31'b0, ovf4}, {31'b0, e.ovf});
        check("nc4_busy_falls", {31'b0, busy4}, 32'd0);
      end
    end
    prev_done4 = dot_done4;
  end

  always @(negedge clk) begin
    if (rst_n && dot_done1) begin
      exp_t e;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL nc1_unexpected_done: got result %h with nothing pending", dot_result1);
      end else begin
        e = q1.pop_front();
        $display("txn nc1 result=%h latency=%0d (expect %h latency=2)",
                 dot_result1, cyc_cnt - chunk1_cyc, e.result);
        check("nc1_result", dot_result1, e.result);
        check("nc1_latency", cyc_cnt - chunk1_cyc, 32'd2);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start4();
    dot_start4 = 1'b1;
    cyc(1);
    dot_start4 = 1'b0;
  endtask

  task automatic chunk4(input logic [31:0] v);
    chunk_valid4 = 1'b1;
    chunk_sum4   = v;
    cyc(1);
    chunk_valid4 = 1'b0;
  endtask

  task automatic wait_q4(input int lim);
    int n = 0;
    while (q4.size() != 0 && n < lim) begin
      cyc(1);
      n++;
    end
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL nc4_done_timeout: pending %0d, required 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic wait_q1(input int lim);
    int n = 0;
    while (q1.size() != 0 && n < lim) begin
      cyc(1);
      n++;
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL nc1_done_timeout: pending %0d, required 0", q1.size());
      q1.delete();
    end
  endtask

  function automatic vec_t mk(input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [31:0] c3,
                              input int gap, input logic [31:0] exp);
    vec_t v;
    v.c[0] = c0;
    v.c[1] = c1;
    v.c[2] = c2;
    v.c[3] = c3;
    v.gap  = gap;
    v.exp  = exp;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    q4.push_back({v.exp, 1'b0});
    start4();
    check("nc4_busy_after_start", {31'b0, busy4}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chunk4(v.c[k]);
      if (v.gap > 1) cyc(v.gap - 1);
    end
    wait_q4(200);
    cyc(5);
    check("nc4_result_holds", dot_result4, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 20, 32'h41200000);
    vecs[1] = mk(32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000, 20, 32'h41200000);
    vecs[2] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3,  32'h40800000);
    vecs[3] = mk(32'hBF800000, 32'h40400000, 32'h3F000000, 32'h40200000, 8,  32'h40A00000);
    vecs[4] = mk(32'h40000000, 32'hC0000000, 32'h3FC00000, 32'h3E800000, 6,  32'h3FE00000);

    rst_n = 1'b0;
    dot_start4 = 1'b0; chunk_valid4 = 1'b0; chunk_sum4 = '0;
    dot_start1 = 1'b0; chunk_valid1 = 1'b0; chunk_sum1 = '0;
    #12;
    check("reset_dot_result", dot_result4, 32'd0);
    check("reset_dot_done", {31'b0, dot_done4}, 32'd0);
    check("reset_busy", {31'b0, busy4}, 32'd0);
    check("reset_overflow", {31'b0, ovf4}, 32'd0);
    check("reset_nc1_dot_result", dot_result1, 32'd0);
    check("reset_nc1_busy", {31'b0, busy1}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Four back-to-back chunks: third is held, fourth overflows and is dropped.
    q4.push_back({32'h41200000, 1'b1});
    start4();
    chunk4(32'h3F800000);
    chunk4(32'h40000000);
    chunk4(32'h40400000);
    chunk4(32'h40800000);
    cyc(20);
    check("ovf_sticky_before_done", {31'b0, ovf4}, 32'd1);
    check("ovf_still_busy", {31'b0, busy4}, 32'd1);
    check("ovf_waiting_for_chunk", q4.size(), 32'd1);
    chunk4(32'h40800000);
    wait_q4(200);

    // Second chunk starts an add, third lands in the holding register.
    q4.push_back({32'h41200000, 1'b0});
    start4();
    chunk4(32'h3F800000);
    cyc(4);
    chunk4(32'h40000000);
    chunk4(32'h40400000);
    cyc(15);
    chunk4(32'h40800000);
    wait_q4(200);

    // Abort mid-run; earlier chunks must not leak into the restarted sum.
    q4.push_back({32'h40800000, 1'b0});
    start4();
    chunk4(32'h40400000);
    cyc(5);
    chunk4(32'h40A00000);
    start4();
    check("abort_busy", {31'b0, busy4}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chunk4(32'h3F800000);
      cyc(9);
    end
    wait_q4(200);

    // Asynchronous reset while an add is in flight.
    start4();
    chunk4(32'h3F800000);
    cyc(3);
    chunk4(32'h40000000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midadd_reset_dot_result", dot_result4, 32'd0);
    check("midadd_reset_dot_done", {31'b0, dot_done4}, 32'd0);
    check("midadd_reset_busy", {31'b0, busy4}, 32'd0);
    check("midadd_reset_overflow", {31'b0, ovf4}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);
    apply_vec(vecs[0]);

    // NC=1: chunk in IDLE ignored, then single-chunk runs.
    chunk_valid1 = 1'b1; chunk_sum1 = 32'h3F800000;
    cyc(1);
    chunk_valid1 = 1'b0;
    cyc(5);
    check("nc1_idle_chunk_busy", {31'b0, busy1}, 32'd0);
    check("nc1_idle_chunk_result", dot_result1, 32'd0);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h40400000 : 32'hC0000000;
      q1.push_back({v, 1'b0});
      dot_start1 = 1'b1;
      cyc(1);
      dot_start1 = 1'b0;
      chunk1_cyc = cyc_cnt;
      chunk_valid1 = 1'b1; chunk_sum1 = v;
      cyc(1);
      chunk_valid1 = 1'b0;
      wait_q1(20);
      cyc(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
